// File: rtl/simple_circuit_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module      : simple_circuit_sweeper_if
// Description : Start/abort handshake, circuit stimulus/response and result bus
// Revision    : 1.0
// ============================================================================
interface simple_circuit_sweeper_if;
    logic       start;
    logic       abort;
    logic       D;
    logic       E;
    logic       A;
    logic       B;
    logic       C;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] d_vec;
    logic [7:0] e_vec;
    logic [7:0] mismatch;

    // Lab / bench side: issues requests and returns the circuit responses
    modport master (
        output start, abort, D, E,
        input  A, B, C, busy, done, pass, d_vec, e_vec, mismatch
    );

    modport slave (
        input  start, abort, D, E,
        output A, B, C, busy, done, pass, d_vec, e_vec, mismatch
    );
endinterface
`default_nettype wire

// File: rtl/simple_circuit_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : simple_circuit_sweeper
// Description : Steps {A,B,C} through all 8 vectors, captures D/E, checks them
// Revision    : 1.0
// ============================================================================
module simple_circuit_sweeper #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] EXP_D         = 8'hD5,
    parameter logic [7:0] EXP_E         = 8'h55
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    simple_circuit_sweeper_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
    localparam logic [3:0] c_SETTLE  = 4'(SETTLE_CYCLES);
    localparam logic [2:0] c_LAST    = 3'd7;

    logic [1:0] r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_d_vec;
    logic [7:0] r_e_vec;
    logic [7:0] r_mismatch;

    logic       w_start_ok;
    logic       w_sample;
    logic       w_mm_bit;
    logic [7:0] w_mismatch_next;

    assign w_start_ok      = bus.start & ~bus.abort;
    assign w_sample        = (r_cnt == c_SETTLE);
    assign w_mm_bit        = (bus.D != EXP_D[r_idx]) | (bus.E != EXP_E[r_idx]);
    // pass on entry to DONE must include the final vector's verdict
    assign w_mismatch_next = r_mismatch | ({7'd0, w_mm_bit} << r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_idx      <= 3'd0;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_d_vec    <= 8'h00;
            r_e_vec    <= 8'h00;
            r_mismatch <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state    <= c_ST_RUN;
                        r_idx      <= 3'd0;
                        r_cnt      <= 4'd0;
                        r_busy     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_d_vec    <= 8'h00;
                        r_e_vec    <= 8'h00;
                        r_mismatch <= 8'h00;
                    end
                end
                c_ST_RUN: begin
                    // Abort takes precedence over a capture due on the same edge
                    if (bus.abort) begin
                        r_state <= c_ST_IDLE;
                        r_idx   <= 3'd0;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                    end else if (w_sample) begin
                        r_d_vec[r_idx] <= bus.D;
                        r_e_vec[r_idx] <= bus.E;
                        r_mismatch     <= w_mismatch_next;
                        r_cnt          <= 4'd0;
                        if (r_idx == c_LAST) begin
                            r_state <= c_ST_DONE;
                            r_idx   <= 3'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_mismatch_next == 8'h00);
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_idx   <= 3'd0;
                    r_cnt   <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // r_idx is forced to 0 outside RUN, so it doubles as the stimulus register
    assign bus.A        = r_idx[2];
    assign bus.B        = r_idx[1];
    assign bus.C        = r_idx[0];
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pass     = r_pass;
    assign bus.d_vec    = r_d_vec;
    assign bus.e_vec    = r_e_vec;
    assign bus.mismatch = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_simple_circuit_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_circuit_sweeper
// Description : Randomized self-checking bench for simple_circuit_sweeper
// Revision    : 1.0
// ============================================================================
module tb_simple_circuit_sweeper;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic sel;          // 0: S=2 instance, 1: S=0 instance
    logic force_d0;
    logic [7:0] d_flip;
    logic [7:0] e_flip;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    simple_circuit_sweeper_if b2 ();
    simple_circuit_sweeper_if b0 ();

    simple_circuit_sweeper #(.SETTLE_CYCLES(2), .EXP_D(8'hD5), .EXP_E(8'h55)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    simple_circuit_sweeper #(.SETTLE_CYCLES(0), .EXP_D(8'hD5), .EXP_E(8'h55)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    // Attached circuit: D = AB + C', E = C', with optional per-vector faults
    always_comb begin
        b2.start = start & ~sel;
        b2.abort = abort & ~sel;
        b0.start = start & sel;
        b0.abort = abort & sel;
        b2.D = force_d0 ? 1'b0 : (((b2.A & b2.B) | ~b2.C) ^ d_flip[{b2.A, b2.B, b2.C}]);
        b2.E = ~b2.C ^ e_flip[{b2.A, b2.B, b2.C}];
        b0.D = force_d0 ? 1'b0 : (((b0.A & b0.B) | ~b0.C) ^ d_flip[{b0.A, b0.B, b0.C}]);
        b0.E = ~b0.C ^ e_flip[{b0.A, b0.B, b0.C}];
    end

    logic       o_busy, o_done, o_pass;
    logic [2:0] o_abc;
    logic [7:0] o_dvec, o_evec, o_mm;

    always_comb begin
        o_busy = sel ? b0.busy : b2.busy;
        o_done = sel ? b0.done : b2.done;
        o_pass = sel ? b0.pass : b2.pass;
        o_abc  = sel ? {b0.A, b0.B, b0.C} : {b2.A, b2.B, b2.C};
        o_dvec = sel ? b0.d_vec : b2.d_vec;
        o_evec = sel ? b0.e_vec : b2.e_vec;
        o_mm   = sel ? b0.mismatch : b2.mismatch;
    end

    // ---------------- reference model ----------------
    function automatic logic ideal_d(input int i);
        logic [2:0] v;
        v = 3'(i);
        return (v[2] & v[1]) | ~v[0];
    endfunction

    function automatic logic ideal_e(input int i);
        logic [2:0] v;
        v = 3'(i);
        return ~v[0];
    endfunction

    function automatic logic [7:0] model_d();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = force_d0 ? 1'b0 : (ideal_d(i) ^ d_flip[i]);
        return r;
    endfunction

    function automatic logic [7:0] model_e();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = ideal_e(i) ^ e_flip[i];
        return r;
    endfunction

    function automatic logic [7:0] model_mm();
        logic [7:0] r;
        logic [7:0] d;
        logic [7:0] e;
        d = model_d();
        e = model_e();
        for (int i = 0; i < 8; i++) r[i] = (d[i] != ideal_d(i)) | (e[i] != ideal_e(i));
        return r;
    endfunction

    function automatic int cur_s();
        return sel ? 0 : 2;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({o_busy, o_done, o_pass, o_abc} !== 6'b0 || o_dvec !== 8'h00 || o_evec !== 8'h00 || o_mm !== 8'h00) begin
                errors++;
                $display("FAIL reset_state sel=%0d got busy=%b done=%b pass=%b abc=%0d d=%h e=%h mm=%h want all zero",
                         s, o_busy, o_done, o_pass, o_abc, o_dvec, o_evec, o_mm);
            end
        end
        sel = 1'b0;
    endtask

    // Caller is at a negedge; start sampled at the next posedge (edge 0)
    task automatic run_sweep(input bit hold);
        int s;
        int n;
        logic       exp_busy, exp_done;
        logic [2:0] exp_abc;
        s = cur_s();
        n = 8 * (s + 1);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 0; k <= n + 1; k++) begin
            if (k > 0) @(negedge clk);
            exp_busy = (k < n);
            exp_done = (k == n);
            exp_abc  = (k < n) ? 3'(k / (s + 1)) : 3'd0;
            checks++;
            if (o_busy !== exp_busy || o_done !== exp_done || o_abc !== exp_abc) begin
                errors++;
                $display("FAIL sweep_timing S=%0d edge=%0d got busy=%b done=%b abc=%0d want busy=%b done=%b abc=%0d",
                         s, k, o_busy, o_done, o_abc, exp_busy, exp_done, exp_abc);
            end
        end
        checks++;
        if (o_dvec !== model_d() || o_evec !== model_e() || o_mm !== model_mm() || o_pass !== (model_mm() == 8'h00)) begin
            errors++;
            $display("FAIL sweep_result S=%0d got d=%h e=%h mm=%h pass=%b want d=%h e=%h mm=%h pass=%b",
                     s, o_dvec, o_evec, o_mm, o_pass, model_d(), model_e(), model_mm(), model_mm() == 8'h00);
        end
    endtask

    task automatic test_correct();
        sel = 1'b0; force_d0 = 1'b0; d_flip = 8'h00; e_flip = 8'h00;
        run_sweep(1'b0);
    endtask

    task automatic test_force_d0();
        sel = 1'b0; force_d0 = 1'b1; d_flip = 8'h00; e_flip = 8'h00;
        run_sweep(1'b0);
        force_d0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel = 1'b1; d_flip = 8'h00; e_flip = 8'h00;
        run_sweep(1'b0);
        run_sweep(1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            sel    = 1'($urandom_range(0, 1));
            d_flip = 8'($urandom);
            e_flip = 8'($urandom);
            if (r == 0) begin
                d_flip = 8'h00;
                e_flip = 8'h80;
            end
            run_sweep(1'b0);
        end
        d_flip = 8'h00; e_flip = 8'h00;
    endtask

    task automatic test_start_held();
        sel = 1'b0;
        d_flip = 8'h01 | 8'($urandom);
        e_flip = 8'($urandom);
        run_sweep(1'b1);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_dvec !== 8'h00 || o_evec !== 8'h00 || o_mm !== 8'h00 || o_pass !== 1'b0) begin
            errors++;
            $display("FAIL held_start_restart got busy=%b d=%h e=%h mm=%h pass=%b want busy=1 results cleared",
                     o_busy, o_dvec, o_evec, o_mm, o_pass);
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_start_abort got busy=%b want 0", o_busy);
        end
        d_flip = 8'h00; e_flip = 8'h00;
    endtask

    task automatic test_abort();
        sel = 1'b0; d_flip = 8'h00; e_flip = 8'h00;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (o_abc !== 3'd3) begin
            errors++;
            $display("FAIL abort_presetup got abc=%0d want 3", o_abc);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (o_busy !== 1'b0 || o_done !== 1'b0 || o_abc !== 3'd0 || o_pass !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle cyc=%0d got busy=%b done=%b abc=%0d pass=%b want 0 0 0 0",
                         k, o_busy, o_done, o_abc, o_pass);
            end
            @(negedge clk);
        end
        checks++;
        if (o_dvec !== (model_d() & 8'h07) || o_evec !== (model_e() & 8'h07) || o_mm !== 8'h00) begin
            errors++;
            $display("FAIL abort_partial got d=%h e=%h mm=%h want d=%h e=%h mm=00",
                     o_dvec, o_evec, o_mm, model_d() & 8'h07, model_e() & 8'h07);
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0; d_flip = 8'h00; e_flip = 8'h00;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        checks++;
        if (o_abc !== 3'd5 || o_dvec !== (model_d() & 8'h1F)) begin
            errors++;
            $display("FAIL reset_mid_presetup got abc=%0d d=%h want abc=5 d=%h", o_abc, o_dvec, model_d() & 8'h1F);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_pass, o_abc} !== 6'b0 || o_dvec !== 8'h00 || o_evec !== 8'h00 || o_mm !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async got busy=%b abc=%0d d=%h e=%h mm=%h want all zero",
                     o_busy, o_abc, o_dvec, o_evec, o_mm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({o_busy, o_done, o_pass, o_abc} !== 6'b0 || o_dvec !== 8'h00 || o_evec !== 8'h00) begin
                errors++;
                $display("FAIL reset_mid_hold cyc=%0d got busy=%b abc=%0d d=%h e=%h want all zero",
                         k, o_busy, o_abc, o_dvec, o_evec);
            end
        end
        run_sweep(1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
        force_d0 = 1'b0; d_flip = 8'h00; e_flip = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_correct();
        test_force_d0();
        test_back_to_back();
        test_random();
        test_start_held();
        @(negedge clk);
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
